// File: rtl/net_egress_rr_arbiter_if.sv
// Bundle of AXI-stream signals for LANES parallel streams, packed lane-major.
// The arbiter uses one instance for all masters and one single-lane instance for its output.
interface net_egress_rr_arbiter_if #(
    parameter int unsigned LANES  = 1,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEST_W = 4
);
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES*ID_W-1:0]   tid;
    logic [LANES*DEST_W-1:0] tdest;
    logic [LANES*KEEP_W-1:0] tkeep;
    logic [LANES-1:0]        tlast;
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;

    modport master (
        output tdata, tid, tdest, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tid, tdest, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/net_egress_rr_arbiter.sv
// Packet-granular round-robin merge of per-master egress streams into one registered
// egress stream; the grant only moves on after the locked packet's tlast is accepted.
module net_egress_rr_arbiter #(
    parameter int unsigned AXIS_BUS_WIDTH  = 64,
    parameter int unsigned AXIS_ID_WIDTH   = 4,
    parameter int unsigned AXIS_DEST_WIDTH = 4,
    parameter int unsigned NUM_MASTERS     = 4,
    localparam int unsigned PTR_WIDTH      = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    net_egress_rr_arbiter_if.slave  axis_egr_in_all,
    net_egress_rr_arbiter_if.master axis_egr_out,
    output logic [PTR_WIDTH-1:0]    cur_grant
);
    localparam int unsigned DATA_W = AXIS_BUS_WIDTH;
    localparam int unsigned ID_W   = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH;
    localparam int unsigned DEST_W = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH;
    localparam int unsigned KEEP_W = DATA_W / 8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                 state;
    logic [PTR_WIDTH-1:0]   g;
    logic                   out_valid;
    logic                   out_last;
    logic [DATA_W-1:0]      out_data;
    logic [ID_W-1:0]        out_id;
    logic [DEST_W-1:0]      out_dest;
    logic [KEEP_W-1:0]      out_keep;

    logic                   slot_free_c;
    logic                   capture_c;
    logic                   any_valid_c;
    logic [PTR_WIDTH-1:0]   next_idx_c;
    logic [NUM_MASTERS-1:0] tready_c;
    logic [DATA_W-1:0]      sel_data_c;
    logic [ID_W-1:0]        sel_id_c;
    logic [DEST_W-1:0]      sel_dest_c;
    logic [KEEP_W-1:0]      sel_keep_c;
    logic                   sel_last_c;

    assign slot_free_c = !out_valid || axis_egr_out.tready[0];
    assign any_valid_c = |axis_egr_in_all.tvalid;
    assign capture_c   = (state == S_LOCKED) && axis_egr_in_all.tvalid[g] && slot_free_c;

    // First requesting master after g, wrapping modulo NUM_MASTERS, so g itself is scanned last.
    always_comb begin
        logic found;
        found      = 1'b0;
        next_idx_c = g;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            int unsigned idx;
            idx = (32'(g) + k) % NUM_MASTERS;
            if (!found && axis_egr_in_all.tvalid[idx]) begin
                found      = 1'b1;
                next_idx_c = PTR_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        tready_c = '0;
        if (state == S_LOCKED) begin
            tready_c[g] = slot_free_c;
        end
    end

    always_comb begin
        sel_data_c = axis_egr_in_all.tdata[32'(g)*DATA_W +: DATA_W];
        sel_id_c   = axis_egr_in_all.tid[32'(g)*ID_W +: ID_W];
        sel_dest_c = axis_egr_in_all.tdest[32'(g)*DEST_W +: DEST_W];
        sel_keep_c = axis_egr_in_all.tkeep[32'(g)*KEEP_W +: KEEP_W];
        sel_last_c = axis_egr_in_all.tlast[g];
    end

    // Arbitration state plus the one-deep output register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= S_IDLE;
            g         <= PTR_WIDTH'(NUM_MASTERS - 1);
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_dest  <= '0;
            out_keep  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid_c) begin
                        g     <= next_idx_c;
                        state <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (capture_c && sel_last_c) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (capture_c) begin
                out_valid <= 1'b1;
                out_last  <= sel_last_c;
                out_data  <= sel_data_c;
                out_id    <= sel_id_c;
                out_dest  <= sel_dest_c;
                out_keep  <= sel_keep_c;
            end else if (axis_egr_out.tready[0]) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign axis_egr_in_all.tready = tready_c;
    assign axis_egr_out.tvalid    = out_valid;
    assign axis_egr_out.tlast     = out_last;
    assign axis_egr_out.tdata     = out_data;
    assign axis_egr_out.tid       = out_id;
    assign axis_egr_out.tdest     = out_dest;
    assign axis_egr_out.tkeep     = out_keep;
    assign cur_grant              = g;

endmodule

// File: tb/tb_net_egress_rr_arbiter.sv
// Directed bench for net_egress_rr_arbiter: per-cycle vector table plus sequences
// for round-robin order, mid-packet stall, output backpressure and reset.
module tb_net_egress_rr_arbiter;
    localparam int DW   = 64;
    localparam int IW   = 4;
    localparam int DSTW = 4;
    localparam int NM   = 4;
    localparam int KW   = DW / 8;

    logic       aclk = 1'b0;
    logic       areset;
    logic [1:0] cur_grant;

    always #5 aclk = ~aclk;

    net_egress_rr_arbiter_if #(.LANES(NM), .DATA_W(DW), .ID_W(IW), .DEST_W(DSTW)) in_if ();
    net_egress_rr_arbiter_if #(.LANES(1),  .DATA_W(DW), .ID_W(IW), .DEST_W(DSTW)) out_if ();

    net_egress_rr_arbiter #(
        .AXIS_BUS_WIDTH (DW),
        .AXIS_ID_WIDTH  (IW),
        .AXIS_DEST_WIDTH(DSTW),
        .NUM_MASTERS    (NM)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .axis_egr_in_all(in_if.slave),
        .axis_egr_out   (out_if.master),
        .cur_grant      (cur_grant)
    );

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic       otr;
        logic [3:0] exp_tready;
        logic       exp_ov;
        logic       exp_ol;
        logic [1:0] exp_gr;
        int         exp_src;
        int         exp_b;
    } vec_t;

    vec_t tbl[13];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [NM-1:0] en;
    logic        otr;
    int          plen[NM];
    int          bidx[NM];
    int          pkts_done[NM];

    int   obs_src[$];
    int   obs_beat[$];
    int   obs_cyc[$];
    logic obs_last[$];
    logic obs_ok[$];

    function automatic logic [DW-1:0] pdata(int m, int b);
        return {8'(m), 8'(b), 16'hBEEF, 32'(m * 1000 + b * 7 + 32'h1234_0000)};
    endfunction

    function automatic logic [KW-1:0] pkeep(int b);
        return KW'(255 >> b);
    endfunction

    function automatic logic [DSTW-1:0] pdest(int m, int b);
        return DSTW'(m + b + 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive every master's lane from the bench's per-master packet position.
    task automatic apply();
        for (int m = 0; m < NM; m++) begin
            in_if.tvalid[m]               = en[m];
            in_if.tlast[m]                = (bidx[m] == plen[m] - 1);
            in_if.tdata[m*DW +: DW]       = pdata(m, bidx[m]);
            in_if.tid[m*IW +: IW]         = IW'(m);
            in_if.tdest[m*DSTW +: DSTW]   = pdest(m, bidx[m]);
            in_if.tkeep[m*KW +: KW]       = pkeep(bidx[m]);
        end
        out_if.tready[0] = otr;
    endtask

    // Record handshakes before the edge, advance the upstream model after it.
    task automatic tick();
        logic [NM-1:0] hs;
        int src;
        int tag;
        hs = in_if.tvalid & in_if.tready;
        if (out_if.tvalid[0] === 1'b1 && otr) begin
            src = int'(out_if.tid);
            tag = int'(out_if.tdata[55:48]);
            obs_src.push_back(src);
            obs_beat.push_back(tag);
            obs_last.push_back(out_if.tlast[0]);
            obs_cyc.push_back(cyc);
            obs_ok.push_back(out_if.tdata === pdata(src, tag) &&
                             out_if.tkeep === pkeep(tag) &&
                             out_if.tdest === pdest(src, tag));
        end
        @(posedge aclk);
        #1;
        cyc++;
        for (int m = 0; m < NM; m++) begin
            if (areset) begin
                bidx[m] = 0;
            end else if (hs[m]) begin
                if (bidx[m] == plen[m] - 1) begin
                    bidx[m] = 0;
                    pkts_done[m]++;
                end else begin
                    bidx[m]++;
                end
            end
        end
        apply();
    endtask

    task automatic clear_obs();
        obs_src.delete();
        obs_beat.delete();
        obs_cyc.delete();
        obs_last.delete();
        obs_ok.delete();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        en     = '0;
        otr    = 1'b1;
        for (int m = 0; m < NM; m++) begin
            bidx[m]      = 0;
            pkts_done[m] = 0;
        end
        apply();
        tick();
        tick();
        areset = 1'b0;
        apply();
        clear_obs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        en     = '0;
        otr    = 1'b1;
        plen[0] = 4; plen[1] = 2; plen[2] = 3; plen[3] = 2;

        //          rst   en       otr   tready   ov    ol    gr    src b
        tbl[0]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 0, 0};
        tbl[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0, 2'd2, 0, 0};
        tbl[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd2, 2, 0};
        tbl[3]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd2, 2, 1};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 2, 2};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 0, 0};
        tbl[6]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 0, 0};
        tbl[7]  = '{1'b0, 4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 0, 0};
        tbl[8]  = '{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 0, 0};
        tbl[9]  = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 0, 0};
        tbl[10] = '{1'b0, 4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 0, 0};
        tbl[11] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 0, 0};
        tbl[12] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 0, 0};

        do_reset();
        #1;
        check("reset_tready", 64'(in_if.tready), 64'(0));
        check("reset_out_tvalid", 64'(out_if.tvalid), 64'(0));
        check("reset_out_tlast", 64'(out_if.tlast), 64'(0));
        check("reset_out_tdata", out_if.tdata, 64'(0));
        check("reset_cur_grant", 64'(cur_grant), 64'(3));

        // Single packet from master 2, then reset/wrap behaviour from master 0.
        for (int r = 0; r < 13; r++) begin
            areset = tbl[r].rst;
            en     = tbl[r].en;
            otr    = tbl[r].otr;
            apply();
            #1;
            check($sformatf("vec%0d_tready", r), 64'(in_if.tready), 64'(tbl[r].exp_tready));
            check($sformatf("vec%0d_tvalid", r), 64'(out_if.tvalid), 64'(tbl[r].exp_ov));
            check($sformatf("vec%0d_grant", r), 64'(cur_grant), 64'(tbl[r].exp_gr));
            if (tbl[r].exp_ov) begin
                check($sformatf("vec%0d_tlast", r), 64'(out_if.tlast), 64'(tbl[r].exp_ol));
                check($sformatf("vec%0d_tdata", r), out_if.tdata, pdata(tbl[r].exp_src, tbl[r].exp_b));
                check($sformatf("vec%0d_tid", r), 64'(out_if.tid), 64'(tbl[r].exp_src));
                check($sformatf("vec%0d_tkeep", r), 64'(out_if.tkeep), 64'(pkeep(tbl[r].exp_b)));
            end
            tick();
        end

        // All masters continuously valid with 2-beat packets.
        do_reset();
        for (int m = 0; m < NM; m++) plen[m] = 2;
        en = 4'b1111;
        apply();
        for (int c = 0; c < 20; c++) tick();
        check("rr_enough_beats", 64'(obs_src.size() >= 10), 64'(1));
        for (int k = 0; k < 10 && k < obs_src.size(); k++) begin
            check($sformatf("rr_src%0d", k), 64'(obs_src[k]), 64'((k / 2) % 4));
            check($sformatf("rr_beat%0d", k), 64'(obs_beat[k]), 64'(k % 2));
            check($sformatf("rr_last%0d", k), 64'(obs_last[k]), 64'(k % 2));
            check($sformatf("rr_payload%0d", k), 64'(obs_ok[k]), 64'(1));
            if (k > 0)
                check($sformatf("rr_gap%0d", k), 64'(obs_cyc[k] - obs_cyc[k-1]), 64'((k % 2 == 0) ? 2 : 1));
        end

        // Master 1 locked, stalls mid-packet while master 3 waits.
        do_reset();
        plen[1] = 3;
        plen[3] = 2;
        en = 4'b0010;
        apply();
        tick();
        #1;
        check("stall_lock_grant", 64'(cur_grant), 64'(1));
        tick();
        for (int i = 0; i < 5; i++) begin
            en = 4'b1000;
            apply();
            #1;
            check("stall_tready3", 64'(in_if.tready[3]), 64'(0));
            check("stall_grant", 64'(cur_grant), 64'(1));
            tick();
        end
        begin
            int guard;
            guard = 0;
            en = 4'b1010;
            apply();
            while (pkts_done[1] == 0 && guard < 10) begin
                #1;
                check("stall_resume_tready3", 64'(in_if.tready[3]), 64'(0));
                tick();
                guard++;
            end
            check("stall_tlast_within_budget", 64'(pkts_done[1] != 0), 64'(1));
        end
        en = 4'b1000;
        apply();
        for (int c = 0; c < 8; c++) tick();
        check("stall_obs_count", 64'(obs_src.size() >= 5), 64'(1));
        for (int k = 0; k < 5 && k < obs_src.size(); k++) begin
            check($sformatf("stall_src%0d", k), 64'(obs_src[k]), 64'((k < 3) ? 1 : 3));
            check($sformatf("stall_beat%0d", k), 64'(obs_beat[k]), 64'((k < 3) ? k : k - 3));
            check($sformatf("stall_last%0d", k), 64'(obs_last[k]), 64'(k == 2 || k == 4));
            check($sformatf("stall_payload%0d", k), 64'(obs_ok[k]), 64'(1));
        end

        // out_tready toggling 1010 during a 4-beat packet from master 0.
        do_reset();
        plen[0] = 4;
        begin
            logic [DW-1:0] held;
            logic          stalled;
            held    = '0;
            stalled = 1'b0;
            en      = 4'b0001;
            for (int c = 0; c < 16; c++) begin
                if (pkts_done[0] != 0) en = '0;
                otr = (c % 2 == 0);
                apply();
                #1;
                if (stalled) begin
                    check("bp_hold_valid", 64'(out_if.tvalid), 64'(1));
                    check("bp_hold_data", out_if.tdata, held);
                end
                if (out_if.tvalid[0] === 1'b1 && !otr)
                    check("bp_tready_drop", 64'(in_if.tready[0]), 64'(0));
                stalled = (out_if.tvalid[0] === 1'b1) && !otr;
                held    = out_if.tdata;
                tick();
            end
        end
        check("bp_beat_count", 64'(obs_src.size()), 64'(4));
        for (int k = 0; k < 4 && k < obs_src.size(); k++) begin
            check($sformatf("bp_src%0d", k), 64'(obs_src[k]), 64'(0));
            check($sformatf("bp_beat%0d", k), 64'(obs_beat[k]), 64'(k));
            check($sformatf("bp_last%0d", k), 64'(obs_last[k]), 64'(k == 3));
            check($sformatf("bp_payload%0d", k), 64'(obs_ok[k]), 64'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/net_egress_rr_arbiter.md
# net_egress_rr_arbiter

Packet-granular round-robin multiplexer that merges the NUM_MASTERS per-master egress AXI streams into the single egress stream feeding the network MAC/shell. It sits directly downstream of the per-master network bandwidth throttlers, on their egress outputs. A packet, once granted, is forwarded atomically through a one-deep registered output stage. Grant moves to the next requesting master only after tlast is accepted.

## Interface
Parameters:
- AXIS_BUS_WIDTH, 64, tdata width in bits; tkeep is AXIS_BUS_WIDTH/8.
- AXIS_ID_WIDTH, 4, tid width; a value <1 is treated as 1.
- AXIS_DEST_WIDTH, 4, tdest width; a value <1 is treated as 1.
- NUM_MASTERS, 4, number of input streams, ≥2.
- PTR_WIDTH, derived = max(1, $clog2(NUM_MASTERS)), grant pointer width.

Ports:
- aclk  in  1  the single clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- axis_egr_in_all_tdata  in  AXIS_BUS_WIDTH ×NUM_MASTERS  per-master data.
- axis_egr_in_all_tid / _tdest  in  ID/DEST width ×NUM_MASTERS  per-master sideband.
- axis_egr_in_all_tkeep  in  AXIS_BUS_WIDTH/8 ×NUM_MASTERS  byte enables.
- axis_egr_in_all_tlast / _tvalid  in  1 ×NUM_MASTERS  per-master handshake.
- axis_egr_in_all_tready  out  1 ×NUM_MASTERS  per-master ready.
- axis_egr_out_tdata/_tid/_tdest/_tkeep/_tlast  out  matching widths  merged stream, registered.
- axis_egr_out_tvalid  out  1;  axis_egr_out_tready  in  1.
- cur_grant  out  PTR_WIDTH  index of the locked or last-served master, for debug.

## Operation
- States: IDLE, LOCKED. The registers are state, grant pointer g, and the output register (valid and payload).
- IDLE: all input treadys are 0. If any tvalid is set, select the first valid master scanning g+1, g+2, … with modulo-NUM_MASTERS wrap. Load g with that index and go to LOCKED. If no tvalid is set, stay in IDLE and keep g.
- LOCKED: define slot_free = !out_tvalid || out_tready.
  - in_tready[g] = slot_free. All other treadys are 0.
  - On in_tvalid[g] && slot_free, capture the beat (data, tid, tdest, tkeep, tlast are all passed unmodified) and set out_tvalid=1.
  - If the captured beat has tlast=1, go to IDLE. g stays at the served master, so it has lowest priority next time.
- Output register: if out_tready=1 and no new beat is captured, clear out_tvalid. Payload is held stable while out_tvalid && !out_tready.
- The grant is never revoked mid-packet, even if the granted master stalls (tvalid low). No timeout is applied; upstream throttlers guarantee whole packets.
- A master raising tvalid while another is locked waits. No beats are dropped or reordered, and packets are never interleaved.
- Only the tvalid of inputs is used for arbitration. A tlast-only single-beat packet is valid.

## Timing
- Reset values: state=IDLE, g=NUM_MASTERS-1 (so master 0 wins first), out_tvalid=0, out_tlast=0, out payload=0, all in_tready=0, cur_grant=NUM_MASTERS-1.
- Reset mid-packet: the partial packet is abandoned and the output register is cleared in the same edge. No tlast is emitted; upstream recovery is the system's responsibility.
- Latency: tvalid rises in IDLE at cycle 0 → LOCKED at cycle 1, in_tready high at cycle 1 → first out_tvalid at cycle 2.
- Throughput: 1 beat/cycle inside a packet while out_tready=1. Exactly one IDLE bubble cycle follows each tlast; this is required behaviour.
- Backpressure: out_tready low holds the beat, and in_tready[g] drops in the same cycle (combinational from out_tvalid/out_tready).
- Simultaneous: tlast capture and a new tvalid on another master in the same cycle → the new master is arbitrated in the following IDLE cycle, not earlier.
- Wrap: with g=NUM_MASTERS-1, scanning starts at master 0.

## Test plan
- Reset, then master 2 sends a 3-beat packet, out_tready=1 → in_tready[2] high at cycle 1; out beats on cycles 2–4 with identical tdata/tkeep/tid/tdest; tlast on the 3rd beat; cur_grant=2.
- All 4 masters continuously valid, 2-beat packets → output packet order 0,1,2,3,0,…; one bubble cycle between packets; no interleaving.
- Master 1 locked and stalls tvalid for 5 cycles mid-packet while master 3 is valid → master 3's tready stays 0 until master 1's tlast is accepted; master 3 is served next.
- out_tready toggles 1010… during a 4-beat packet → every beat appears exactly once, and payload is stable while stalled.
- areset asserted mid-packet on master 0, then released → out_tvalid=0 on the next cycle, and all treadys are 0. The next packet from master 0 or master 1 arbitrates starting from master 0.
- g=3 (last served) with masters 0 and 2 valid → master 0 granted (wrap-around).
